// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one dual-port SRAM (port A write, port B read)
// between two requesters. At most one command is granted per cycle. Read
// data comes back one cycle after the grant in a shared registered bus,
// qualified by a per-requester valid.
//
// Build option: define SRAM_ARB_FIXED_PRIO_EN to make requester 0 always win
// ties (fixed priority). Without it, ties alternate round-robin.
module sram_port_arbiter #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0]            req_write_i,
  input  logic [1:0][AW-1:0]    req_addr_i,
  input  logic [1:0][WIDTH-1:0] req_wdata_i,
  output logic [1:0]            rsp_valid_o,
  output logic [WIDTH-1:0]      rsp_rdata_o,
  output logic                  enable_a_n,
  output logic                  write_enable_a_n,
  output logic [AW-1:0]         address_a,
  output logic [WIDTH-1:0]      data_a,
  output logic                  enable_b_n,
  output logic                  write_enable_b_n,
  output logic [AW-1:0]         address_b,
  output logic [WIDTH-1:0]      data_b,
  input  logic [WIDTH-1:0]      q_b
);

  logic [1:0]       w_grant;
  logic             w_winner;
  logic             w_anyGrant;
  logic             w_wrGrant;
  logic             w_rdGrant;
  logic [1:0]       r_rspValid;
  logic [WIDTH-1:0] r_rspRdata;

`ifndef SRAM_ARB_FIXED_PRIO_EN
  // Index of the requester granted most recently; 1 after reset so that
  // requester 0 wins the first tie.
  logic r_lastGrant;
`endif

  // Pick the winner for this cycle; nothing is granted while in reset.
  always_comb begin
    w_grant = 2'b00;
    if (rst_n) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      if (req_valid_i[0]) begin
        w_grant = 2'b01;
      end else if (req_valid_i[1]) begin
        w_grant = 2'b10;
      end
`else
      if (req_valid_i == 2'b11) begin
        w_grant = r_lastGrant ? 2'b01 : 2'b10;
      end else begin
        w_grant = req_valid_i;
      end
`endif
    end
  end

  assign w_winner   = w_grant[1];
  assign w_anyGrant = |w_grant;
  assign w_wrGrant  = w_anyGrant & req_write_i[w_winner];
  assign w_rdGrant  = w_anyGrant & ~req_write_i[w_winner];

  assign req_ready_o = w_grant;

  // Port A carries the winner's write; port B carries the winner's read.
  assign enable_a_n       = ~w_wrGrant;
  assign write_enable_a_n = ~w_wrGrant;
  assign address_a        = req_addr_i[w_winner];
  assign data_a           = req_wdata_i[w_winner];
  assign enable_b_n       = ~w_rdGrant;
  assign address_b        = req_addr_i[w_winner];

  // Port B is read-only.
  assign write_enable_b_n = 1'b1;
  assign data_b           = '0;

`ifndef SRAM_ARB_FIXED_PRIO_EN
  // Remember who won, so the other requester gets the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastGrant <= 1'b1;
    end else if (w_anyGrant) begin
      r_lastGrant <= w_winner;
    end
  end
`endif

  // Capture read data at the grant edge and flag it to the reader for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspValid <= 2'b00;
      r_rspRdata <= '0;
    end else begin
      r_rspValid <= w_rdGrant ? w_grant : 2'b00;
      if (w_rdGrant) begin
        r_rspRdata <= q_b;
      end
    end
  end

  assign rsp_valid_o = r_rspValid;
  assign rsp_rdata_o = r_rspRdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scenarios followed by random traffic for
// sram_port_arbiter, with an SRAM model on the memory ports and a
// transaction-level reference model of grants, memory contents and responses.
module tb_sram_port_arbiter;

  localparam int WIDTH = 256;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic                  clk;
  logic                  rst_n;
  logic [1:0]            vValid;
  logic [1:0]            vWrite;
  logic [1:0][AW-1:0]    vAddr;
  logic [1:0][WIDTH-1:0] vWdata;
  logic [1:0]            req_ready_o;
  logic [1:0]            rsp_valid_o;
  logic [WIDTH-1:0]      rsp_rdata_o;
  logic                  enable_a_n;
  logic                  write_enable_a_n;
  logic [AW-1:0]         address_a;
  logic [WIDTH-1:0]      data_a;
  logic                  enable_b_n;
  logic                  write_enable_b_n;
  logic [AW-1:0]         address_b;
  logic [WIDTH-1:0]      data_b;
  logic [WIDTH-1:0]      q_b;

  int compareCount = 0;
  int failCount    = 0;

  // Reference model state
  int               refLast;
  logic [WIDTH-1:0] refMem [DEPTH];
  logic [1:0]       expRspValid;
  logic [WIDTH-1:0] expRdata;

  // SRAM storage behind the DUT's memory ports
  logic [WIDTH-1:0] sramMem [DEPTH];

  sram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (vValid),
    .req_ready_o      (req_ready_o),
    .req_write_i      (vWrite),
    .req_addr_i       (vAddr),
    .req_wdata_i      (vWdata),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_rdata_o      (rsp_rdata_o),
    .enable_a_n       (enable_a_n),
    .write_enable_a_n (write_enable_a_n),
    .address_a        (address_a),
    .data_a           (data_a),
    .enable_b_n       (enable_b_n),
    .write_enable_b_n (write_enable_b_n),
    .address_b        (address_b),
    .data_b           (data_b),
    .q_b              (q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-write, combinational-read SRAM
  always @(posedge clk) begin
    if (!enable_a_n && !write_enable_a_n) sramMem[address_a] <= data_a;
  end
  assign q_b = sramMem[address_b];

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] randWord();
    logic [WIDTH-1:0] w;
    for (int i = 0; i < WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Who should win given the current requests: -1 means nobody.
  function automatic int predictWinner();
    if (vValid == 2'b00) return -1;
    if (vValid == 2'b01) return 0;
    if (vValid == 2'b10) return 1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (refLast == 0) ? 1 : 0;
`endif
  endfunction

  task automatic setIdle();
    vValid = 2'b00;
    vWrite = 2'b00;
    vAddr  = '0;
    vWdata = '0;
  endtask

  task automatic setReq(input int r, input logic wr, input int addr, input logic [WIDTH-1:0] data);
    vValid[r] = 1'b1;
    vWrite[r] = wr;
    vAddr[r]  = addr[AW-1:0];
    vWdata[r] = data;
  endtask

  // One clock cycle: check the grant-cycle outputs, clock, then check responses.
  task automatic stepCycle();
    int         win;
    logic       isWr;
    logic       isRd;
    logic [1:0] expReady;
    #2;
    win      = predictWinner();
    expReady = (win < 0) ? 2'b00 : (2'b01 << win);
    isWr     = (win >= 0) && vWrite[win];
    isRd     = (win >= 0) && !vWrite[win];
    check("req_ready", req_ready_o, expReady);
    check("enable_a_n", enable_a_n, !isWr);
    check("write_enable_a_n", write_enable_a_n, !isWr);
    check("enable_b_n", enable_b_n, !isRd);
    check("write_enable_b_n", write_enable_b_n, 1'b1);
    check("data_b", data_b, '0);
    if (isWr) begin
      check("address_a", address_a, vAddr[win]);
      check("data_a", data_a, vWdata[win]);
    end
    if (isRd) check("address_b", address_b, vAddr[win]);
    @(posedge clk);
    if (isWr) refMem[vAddr[win]] = vWdata[win];
    if (isRd) expRdata = refMem[vAddr[win]];
    expRspValid = isRd ? (2'b01 << win) : 2'b00;
    if (win >= 0) refLast = win;
    #1;
    check("rsp_valid", rsp_valid_o, expRspValid);
    check("rsp_rdata", rsp_rdata_o, expRdata);
  endtask

  // Assert reset asynchronously, check the reset state, release after an edge.
  task automatic doReset();
    rst_n = 1'b0;
    refLast     = 1;
    expRspValid = 2'b00;
    expRdata    = '0;
    #1;
    check("rst_ready", req_ready_o, 2'b00);
    check("rst_enable_a_n", enable_a_n, 1'b1);
    check("rst_write_enable_a_n", write_enable_a_n, 1'b1);
    check("rst_enable_b_n", enable_b_n, 1'b1);
    check("rst_rsp_valid", rsp_valid_o, 2'b00);
    check("rst_rsp_rdata", rsp_rdata_o, '0);
    @(posedge clk);
    #1;
    check("rst_hold_rsp_valid", rsp_valid_o, 2'b00);
    check("rst_hold_ready", req_ready_o, 2'b00);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] ones;
    ones = '1;
    for (int i = 0; i < DEPTH; i++) begin
      sramMem[i] = '0;
      refMem[i]  = '0;
    end
    setIdle();
    rst_n = 1'b1;
    #1;

    // Reset with both requesters already asking
    setReq(0, 1'b0, 1, '0);
    setReq(1, 1'b0, 2, '0);
    doReset();

    // Both valid for four cycles: 0,1,0,1 round-robin (0,0,0,0 fixed priority)
    for (int i = 0; i < 4; i++) begin
      stepCycle();
`ifdef SRAM_ARB_FIXED_PRIO_EN
      check("tie_grant_fixed", rsp_valid_o, 2'b01);
`else
      check("tie_grant_rr", rsp_valid_o, (i % 2 == 0) ? 2'b01 : 2'b10);
`endif
    end

    // r0 writes 0xA5 to address 5, then reads it back the next cycle
    setIdle();
    setReq(0, 1'b1, 5, 'hA5);
    stepCycle();
    setIdle();
    setReq(0, 1'b0, 5, '0);
    stepCycle();
    check("rd_after_wr_valid", rsp_valid_o, 2'b01);
    check("rd_after_wr_data", rsp_rdata_o, 'hA5);
    setIdle();
    stepCycle();
    check("rsp_drop", rsp_valid_o, 2'b00);
    check("rdata_hold", rsp_rdata_o, 'hA5);

    // r1 writes all ones to the top address and reads it back
    setReq(1, 1'b1, DEPTH - 1, ones);
    stepCycle();
    setIdle();
    setReq(1, 1'b0, DEPTH - 1, '0);
    stepCycle();
    check("top_addr_valid", rsp_valid_o, 2'b10);
    check("top_addr_data", rsp_rdata_o, ones);

    // Three idle cycles
    setIdle();
    for (int i = 0; i < 3; i++) stepCycle();

    // Reset in the cycle after a read grant drops the pending response
    setReq(0, 1'b0, 5, '0);
    stepCycle();
    check("pre_reset_valid", rsp_valid_o, 2'b01);
    setIdle();
    doReset();
    setReq(0, 1'b0, 5, '0);
    setReq(1, 1'b0, DEPTH - 1, '0);
    stepCycle();
    check("post_reset_tie", rsp_valid_o, 2'b01);
    check("post_reset_data", rsp_rdata_o, 'hA5);

    // Random traffic over a small address window plus the top address
    for (int i = 0; i < 400; i++) begin
      setIdle();
      for (int r = 0; r < 2; r++) begin
        if ($urandom_range(9) < 6) begin
          setReq(r, 1'($urandom_range(1)),
                 ($urandom_range(7) == 0) ? DEPTH - 1 : int'($urandom_range(7)),
                 randWord());
        end
      end
      stepCycle();
    end

    setIdle();
    stepCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
